fifo_stream_reader: RTL

Read-side controller placed directly downstream of the 8-deep, 32-bit `fifo`. It pops words from the FIFO whenever the FIFO reports data and the block has room. It then presents the words on a valid/ready output stream, using a 2-entry skid buffer to absorb the FIFO's 1-cycle read latency under backpressure. It also marks frame boundaries with `m_last` and keeps a running count of words delivered.

---
 rtl/fifo_pkg.sv | 12 +
 rtl/skid_buf2.sv | 51 +++++
 rtl/fifo_stream_reader.sv | 88 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8x32 FIFO and its stream-side reader.
package fifo_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry circular buffer that absorbs the FIFO's one-cycle read latency.
module skid_buf2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [1:0]        occ_o
);

    logic [1:0][DATA_W-1:0] mem_q;
    logic                   head_q;
    logic                   tail_q;
    logic [1:0]             occ_q;
    logic [1:0]             occ_d;

    always_comb begin
        occ_d = occ_q;
        case ({wr_en_i, rd_en_i})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Writes land on the tail, so the head entry stays put while the reader stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q  <= '0;
            head_q <= 1'b0;
            tail_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (wr_en_i) begin
                mem_q[tail_q] <= wr_data_i;
                tail_q        <= ~tail_q;
            end
            if (rd_en_i) begin
                head_q <= ~head_q;
            end
            occ_q <= occ_d;
        end
    end

    assign rd_data_o = mem_q[head_q];
    assign occ_o     = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the FIFO into a valid/ready stream with frame marking and a word counter.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W    = fifo_pkg::DATA_W,
    parameter int FRAME_LEN = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              fifo_nempty,
    output logic              fifo_read_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic [CNT_W-1:0]  word_count,
    output logic              busy
);

    localparam int          FC_W     = 16;
    localparam logic [FC_W-1:0] LAST_IDX = FC_W'(FRAME_LEN - 1);

    rd_state_t         state_q, state_d;
    logic              inflight_q;
    logic [1:0]        occ;
    logic              pop;
    logic [2:0]        pending;
    logic [FC_W-1:0]   frame_q, frame_d;
    logic [CNT_W-1:0]  count_q;

    skid_buf2 #(.DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (inflight_q),
        .wr_data_i (fifo_data),
        .rd_en_i   (pop),
        .rd_data_o (m_data),
        .occ_o     (occ)
    );

    assign m_valid = (occ != 2'd0);
    assign pop     = m_valid && m_ready;

    // Words already committed to the buffer once this cycle's pop leaves.
    assign pending      = {2'b00, inflight_q} + {1'b0, occ} - {2'b00, pop};
    assign fifo_read_en = (state_q == RUN) && fifo_nempty && (pending < 3'd2);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable)                            state_d = RUN;
                else if (!inflight_q && occ == 2'd0)   state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_d = frame_q;
        if (pop) frame_d = (frame_q == LAST_IDX) ? '0 : frame_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            frame_q    <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_read_en;
            frame_q    <= frame_d;
            if (pop) count_q <= count_q + 1'b1;
        end
    end

    // Gated by valid so a one-word frame does not flag m_last out of reset.
    assign m_last     = m_valid && (frame_q == LAST_IDX);
    assign word_count = count_q;
    assign busy       = (state_q != IDLE);

endmodule
